register_file_sb: RTL and testbench

//   Parametrised successor to the single-write, dual-read register file of the RV32 core.

---
 rtl/register_file_sb_pkg.sv | 11 +
 rtl/register_file_sb_scoreboard.sv | 51 +++++
 rtl/register_file_sb.sv | 98 +++++++++
 tb/tb_register_file_sb.sv | 246 ++++++++++++++++++++++++
 4 files changed

// File: rtl/register_file_sb_pkg.sv
// Shared definitions for the register file: sweep FSM encodings and default geometry.
package register_file_sb_pkg;

    localparam logic RF_INIT = 1'b0;
    localparam logic RF_RUN  = 1'b1;

    localparam int unsigned RF_DATA_W_DEFAULT = 32;
    localparam int unsigned RF_ADDR_W_DEFAULT = 5;
    localparam int unsigned RF_NUM_RD_DEFAULT = 2;

endpackage

// File: rtl/register_file_sb_scoreboard.sv
// Per-register busy scoreboard: set on ALLOC, cleared on writeback, set wins on collision.
module register_file_sb_scoreboard
    import register_file_sb_pkg::*;
#(
    parameter int unsigned ADDR_W = RF_ADDR_W_DEFAULT,
    parameter int unsigned NUM_RD = RF_NUM_RD_DEFAULT
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic                     en_i,
    input  logic                     ld_i,
    input  logic [ADDR_W-1:0]        dr_i,
    input  logic                     alloc_i,
    input  logic [ADDR_W-1:0]        alloc_dr_i,
    input  logic [NUM_RD*ADDR_W-1:0] rd_addr_i,
    output logic [NUM_RD-1:0]        rd_busy_o
);

    localparam int unsigned DEPTH = 2 ** ADDR_W;

    logic [DEPTH-1:0] busy_q, busy_d;

    always_comb begin
        busy_d = busy_q;
        if (en_i) begin
            if (ld_i && dr_i != '0) begin
                busy_d[dr_i] = 1'b0;
            end
            // Applied after the clear so a same-register collision leaves it busy.
            if (alloc_i && alloc_dr_i != '0) begin
                busy_d[alloc_dr_i] = 1'b1;
            end
        end
        busy_d[0] = 1'b0;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            busy_q <= '0;
        end else begin
            busy_q <= busy_d;
        end
    end

    for (genvar i = 0; i < NUM_RD; i++) begin : g_rd_busy
        logic [ADDR_W-1:0] addr;
        assign addr         = rd_addr_i[i*ADDR_W +: ADDR_W];
        assign rd_busy_o[i] = busy_q[addr] & ~(ld_i && dr_i == addr) & en_i;
    end

endmodule

// File: rtl/register_file_sb.sv
// Register file with N bypassed read ports, hard-wired x0, busy scoreboard and
// a post-reset clear sweep that zeroes all registers before READY.
module register_file_sb
    import register_file_sb_pkg::*;
#(
    parameter int unsigned DATA_W = RF_DATA_W_DEFAULT,
    parameter int unsigned ADDR_W = RF_ADDR_W_DEFAULT,
    parameter int unsigned NUM_RD = RF_NUM_RD_DEFAULT
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic                     ld_i,
    input  logic [ADDR_W-1:0]        dr_i,
    input  logic [DATA_W-1:0]        d_in_i,
    input  logic                     alloc_i,
    input  logic [ADDR_W-1:0]        alloc_dr_i,
    input  logic [NUM_RD*ADDR_W-1:0] rd_addr_i,
    output logic [NUM_RD*DATA_W-1:0] rd_data_o,
    output logic [NUM_RD-1:0]        rd_busy_o,
    output logic                     ready_o
);

    localparam int unsigned DEPTH = 2 ** ADDR_W;
    localparam int unsigned CNT_W = ADDR_W + 1;

    logic              state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [DATA_W-1:0] regs_q [DEPTH];
    logic              ready;
    logic              sweep_last;

    assign ready      = (state_q == RF_RUN);
    assign sweep_last = (cnt_q == CNT_W'(DEPTH - 1));
    assign ready_o    = ready;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        if (state_q == RF_INIT) begin
            cnt_d = cnt_q + CNT_W'(1);
            if (sweep_last) begin
                state_d = RF_RUN;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= RF_INIT;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Storage has no reset of its own; the sweep is what clears it.
    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            if (state_q == RF_INIT) begin
                regs_q[cnt_q[ADDR_W-1:0]] <= '0;
            end else if (ld_i && dr_i != '0) begin
                regs_q[dr_i] <= d_in_i;
            end
        end
    end

    for (genvar i = 0; i < NUM_RD; i++) begin : g_rd
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
        assign addr = rd_addr_i[i*ADDR_W +: ADDR_W];
        always_comb begin
            data = regs_q[addr];
            if (!ready || addr == '0) begin
                data = '0;
            end else if (ld_i && dr_i == addr) begin
                data = d_in_i;
            end
        end
        assign rd_data_o[i*DATA_W +: DATA_W] = data;
    end

    register_file_sb_scoreboard #(
        .ADDR_W (ADDR_W),
        .NUM_RD (NUM_RD)
    ) u_scoreboard (
        .clk_i      (clk_i),
        .rst_i      (rst_i),
        .en_i       (ready),
        .ld_i       (ld_i),
        .dr_i       (dr_i),
        .alloc_i    (alloc_i),
        .alloc_dr_i (alloc_dr_i),
        .rd_addr_i  (rd_addr_i),
        .rd_busy_o  (rd_busy_o)
    );

endmodule

// File: tb/tb_register_file_sb.sv
// Directed bench for register_file_sb: reference model compared every negedge plus
// hand-computed literal checks.
module tb_register_file_sb;

    localparam int DW    = 32;
    localparam int AW    = 5;
    localparam int NR    = 2;
    localparam int DEPTH = 32;

    logic             clk = 1'b0;
    logic             rst;
    logic             ld;
    logic [AW-1:0]    dr;
    logic [DW-1:0]    din;
    logic             alloc;
    logic [AW-1:0]    alloc_dr;
    logic [NR*AW-1:0] rd_addr;
    logic [NR*DW-1:0] rd_data;
    logic [NR-1:0]    rd_busy;
    logic             ready;

    int n_vec  = 0;
    int n_miss = 0;

    always #5 clk = ~clk;

    register_file_sb #(
        .DATA_W (DW),
        .ADDR_W (AW),
        .NUM_RD (NR)
    ) dut (
        .clk_i      (clk),
        .rst_i      (rst),
        .ld_i       (ld),
        .dr_i       (dr),
        .d_in_i     (din),
        .alloc_i    (alloc),
        .alloc_dr_i (alloc_dr),
        .rd_addr_i  (rd_addr),
        .rd_data_o  (rd_data),
        .rd_busy_o  (rd_busy),
        .ready_o    (ready)
    );

    // Reference model: "ready" means 32 reset-free cycles have elapsed; at that
    // moment every register is zero.
    logic [DW-1:0] m_regs [DEPTH];
    bit            m_busy [DEPTH];
    bit            m_ready = 0;
    bit            m_valid = 0;
    int            m_cnt   = 0;

    always @(posedge clk) begin
        if (rst) begin
            m_valid = 1;
            m_ready = 0;
            m_cnt   = 0;
            for (int k = 0; k < DEPTH; k++) m_busy[k] = 0;
        end else if (m_valid) begin
            if (!m_ready) begin
                m_cnt = m_cnt + 1;
                if (m_cnt == DEPTH) begin
                    m_ready = 1;
                    for (int k = 0; k < DEPTH; k++) m_regs[k] = '0;
                end
            end else begin
                if (ld && dr != 0) begin
                    m_regs[dr] = din;
                    m_busy[dr] = 0;
                end
                if (alloc && alloc_dr != 0) m_busy[alloc_dr] = 1;
            end
        end
    end

    function automatic logic [DW-1:0] exp_data(input logic [AW-1:0] a);
        if (!m_ready || a == 0) return '0;
        if (ld && dr == a) return din;
        return m_regs[a];
    endfunction

    function automatic logic exp_busy(input logic [AW-1:0] a);
        return m_ready && m_busy[a] && !(ld && dr == a);
    endfunction

    function automatic logic [DW-1:0] port_data(input int p);
        return rd_data[p*DW +: DW];
    endfunction

    task automatic check(input string name, input logic [DW-1:0] act,
                         input logic [DW-1:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (m_valid) begin
            check("model_ready", {31'b0, ready}, {31'b0, m_ready});
            for (int p = 0; p < NR; p++) begin
                check("model_rd_data", port_data(p), exp_data(rd_addr[p*AW +: AW]));
                check("model_rd_busy", {31'b0, rd_busy[p]},
                      {31'b0, exp_busy(rd_addr[p*AW +: AW])});
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_addr(input int p, input logic [AW-1:0] a);
        rd_addr[p*AW +: AW] = a;
    endtask

    logic [AW-1:0] wr_addr [6] = '{5'd1, 5'd10, 5'd17, 5'd31, 5'd2, 5'd20};
    logic [DW-1:0] wr_data [6] = '{32'h0000_0001, 32'hA5A5_5A5A, 32'hFFFF_FFFF,
                                   32'h8000_0000, 32'h1234_5678, 32'h0F0F_F0F0};

    initial begin
        int n;
        rst = 1; ld = 0; dr = '0; din = '0; alloc = 0; alloc_dr = '0; rd_addr = '0;
        tick();
        tick();

        // Sweep, with writes and allocs that must be ignored.
        rst = 0;
        set_addr(0, 5'd3);
        set_addr(1, 5'd6);
        ld = 1; dr = 5'd4; din = 32'd55;
        alloc = 1; alloc_dr = 5'd6;
        for (int i = 1; i < 32; i++) begin
            tick();
            check("sweep_ready_low", {31'b0, ready}, 32'd0);
            check("sweep_rd_zero", port_data(0), 32'd0);
        end
        tick();
        check("sweep_ready_32", {31'b0, ready}, 32'd1);
        ld = 0; alloc = 0;
        set_addr(0, 5'd4);
        #1;
        check("init_write_ignored", port_data(0), 32'd0);
        check("init_alloc_ignored", {31'b0, rd_busy[1]}, 32'd0);

        // Plain write then read.
        ld = 1; dr = 5'd5; din = 32'd123;
        tick();
        ld = 0;
        set_addr(0, 5'd5);
        #1;
        check("write_read_x5", port_data(0), 32'd123);

        // x0 discard, then bypass on port 1.
        ld = 1; dr = 5'd0; din = 32'd7;
        set_addr(0, 5'd0);
        #1;
        check("x0_reads_zero", port_data(0), 32'd0);
        tick();
        dr = 5'd9; din = 32'hDEAD_BEEF;
        set_addr(1, 5'd9);
        #1;
        check("bypass_port1", port_data(1), 32'hDEAD_BEEF);
        tick();
        ld = 0;
        #1;
        check("x9_after_edge", port_data(1), 32'hDEAD_BEEF);

        // Pattern table written then read back on both ports.
        for (int i = 0; i < 6; i++) begin
            ld = 1; dr = wr_addr[i]; din = wr_data[i];
            tick();
        end
        ld = 0;
        for (int i = 0; i < 6; i++) begin
            set_addr(0, wr_addr[i]);
            set_addr(1, wr_addr[5 - i]);
            #1;
            check("table_port0", port_data(0), wr_data[i]);
            check("table_port1", port_data(1), wr_data[5 - i]);
            tick();
        end

        // Scoreboard set / clear / collision.
        alloc = 1; alloc_dr = 5'd7;
        tick();
        alloc = 0;
        set_addr(0, 5'd7);
        #1;
        check("busy_after_alloc", {31'b0, rd_busy[0]}, 32'd1);
        ld = 1; dr = 5'd7; din = 32'h0000_0077;
        #1;
        check("busy_bypassed", {31'b0, rd_busy[0]}, 32'd0);
        tick();
        ld = 0;
        #1;
        check("busy_cleared", {31'b0, rd_busy[0]}, 32'd0);
        ld = 1; dr = 5'd7; din = 32'h0000_0078; alloc = 1; alloc_dr = 5'd7;
        tick();
        ld = 0; alloc = 0;
        #1;
        check("busy_set_wins", {31'b0, rd_busy[0]}, 32'd1);
        check("collision_data", port_data(0), 32'h0000_0078);
        alloc = 1; alloc_dr = 5'd12;
        tick();
        alloc = 0;
        set_addr(1, 5'd12);
        #1;
        check("busy_x12", {31'b0, rd_busy[1]}, 32'd1);

        // Mid-sweep reset restarts the full sweep.
        rst = 1;
        tick();
        rst = 0;
        repeat (10) tick();
        rst = 1;
        tick();
        rst = 0;
        n = 0;
        while (!ready && n < 40) begin
            tick();
            n++;
        end
        check("midsweep_latency", n, 32'd32);
        for (int a = 0; a < DEPTH; a++) begin
            set_addr(0, a[AW-1:0]);
            set_addr(1, a[AW-1:0]);
            #1;
            check("post_sweep_zero", port_data(0), 32'd0);
            check("post_sweep_busy", {31'b0, rd_busy[1]}, 32'd0);
            tick();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: bench did not complete, got running, expected finished");
        $fatal(1, "timeout");
    end

endmodule
